// File: rtl/guess_pkg.sv
// Shared constants, encodings and helpers for the guess-the-number
// game and its autoplayer.
package guess_pkg;

   localparam int MAX_VALUE = 99;
   localparam int DIGIT_W   = 4;

   localparam logic [7:0] HEX_BLANK = 8'hFF;
   localparam logic [7:0] HI3 = 8'h89;
   localparam logic [7:0] HI2 = 8'hF9;
   localparam logic [7:0] LO3 = 8'hC7;
   localparam logic [7:0] LO2 = 8'hC0;
   localparam logic [7:0] OK3 = 8'hC0;
   localparam logic [7:0] OK2 = 8'h88;
   localparam logic [7:0] ER3 = 8'h86;
   localparam logic [7:0] ER2 = 8'hAF;

   typedef enum logic [3:0] {
      S_IDLE,
      S_CLEAR,
      S_COMPUTE,
      S_ONES,
      S_TENS,
      S_SUBMIT,
      S_SETTLE,
      S_CLASSIFY,
      S_FBWAIT,
      S_FINISH
   } state_t;

   typedef enum logic [1:0] {
      H_BAD,
      H_HI,
      H_LO,
      H_OK
   } hint_t;

   typedef enum logic [1:0] {
      T_SUB = 2'd0,
      T_INC = 2'd1,
      T_CLR = 2'd2
   } tgt_t;

   function automatic hint_t decode_hint(
      input logic [7:0] h3,
      input logic [7:0] h2
   );
      hint_t r;
      r = H_BAD;
      unique case (1'b1)
         (h3 == HI3 && h2 == HI2): r = H_HI;
         (h3 == LO3 && h2 == LO2): r = H_LO;
         (h3 == OK3 && h2 == OK2): r = H_OK;
         default:                  r = H_BAD;
      endcase
      return r;
   endfunction

   function automatic logic [DIGIT_W-1:0] digit_dist(
      input logic [DIGIT_W-1:0] tgt,
      input logic [DIGIT_W-1:0] cur
   );
      logic [DIGIT_W:0] d;
      d = 5'(tgt) + 5'd10 - 5'(cur);
      if (d >= 5'd10)
         d = d - 5'd10;
      return 4'(d);
   endfunction

   function automatic logic [DIGIT_W-1:0] digit_inc(
      input logic [DIGIT_W-1:0] d
   );
      return (d == 4'd9) ? 4'd0 : d + 4'd1;
   endfunction

endpackage

// File: rtl/guess_autoplayer_pulser.sv
// Single press generator: one line active for PRESS_CYCLES, then
// released for GAP_CYCLES; a new request is taken on the ack cycle.
module key_pulser
   import guess_pkg::*;
#(
   parameter int unsigned PRESS_CYCLES = 4,
   parameter int unsigned GAP_CYCLES   = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req_i,
   input  tgt_t       tgt_i,
   output logic       ack_o,
   output logic       busy_o,
   output logic [2:0] line_o
);

   logic        busy_q, busy_d;
   logic [31:0] cnt_q, cnt_d;
   logic [2:0]  line_q, line_d;

   assign ack_o  = busy_q && (cnt_q == PRESS_CYCLES + GAP_CYCLES - 1);
   assign busy_o = busy_q;
   assign line_o = line_q;

   always_comb begin
      busy_d = busy_q;
      cnt_d  = cnt_q;
      line_d = line_q;
      if (req_i && (!busy_q || ack_o)) begin
         busy_d = 1'b1;
         cnt_d  = '0;
         line_d = 3'b001 << tgt_i;
      end else if (ack_o) begin
         busy_d = 1'b0;
         cnt_d  = '0;
         line_d = '0;
      end else if (busy_q) begin
         cnt_d = cnt_q + 1;
         if (cnt_d >= PRESS_CYCLES)
            line_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
         line_q <= '0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
         line_q <= line_d;
      end
   end

endmodule

// File: rtl/guess_autoplayer.sv
// Autoplayer: binary-searches the game's secret by pressing its keys
// and decoding the HI/LO/OK hint from the segment outputs.
module guess_autoplayer
   import guess_pkg::*;
#(
   parameter int unsigned PRESS_CYCLES  = 4,
   parameter int unsigned GAP_CYCLES    = 4,
   parameter int unsigned SETTLE_CYCLES = 16,
   parameter int unsigned FB_WAIT       = 6_200_000,
   parameter int unsigned MAX_GUESSES   = 7
) (
   input  logic       MAX10_CLK1_50,
   input  logic       resetN,
   input  logic       start,
   input  logic [7:0] hexIn3,
   input  logic [7:0] hexIn2,
   output logic [1:0] keyOut,
   output logic [2:0] swOut,
   output logic       busy,
   output logic       done,
   output logic       won,
   output logic [6:0] guess,
   output logic [3:0] guessCount
);

   state_t      state_q, state_d;
   logic [6:0]  lo_q, lo_d, hi_q, hi_d, guess_q, guess_d;
   logic [3:0]  ones_q, ones_d, tens_q, tens_d;
   logic [3:0]  rem_o_q, rem_o_d, rem_t_q, rem_t_d;
   logic [3:0]  gcnt_q, gcnt_d;
   logic [31:0] cnt_q, cnt_d;
   logic [1:0]  sel_q, sel_d;
   logic        busy_q, busy_d, done_q, done_d, won_q, won_d;
   logic [7:0]  h3_q, h2_q;

   logic       p_req, p_ack, p_busy, p_free;
   tgt_t       p_tgt;
   logic [2:0] p_line;
   logic [6:0] g_mid;
   logic [3:0] g_ones, g_tens;
   hint_t      hcode;

   key_pulser #(
      .PRESS_CYCLES(PRESS_CYCLES),
      .GAP_CYCLES  (GAP_CYCLES)
   ) u_pulser (
      .clk   (MAX10_CLK1_50),
      .rst_n (resetN),
      .req_i (p_req),
      .tgt_i (p_tgt),
      .ack_o (p_ack),
      .busy_o(p_busy),
      .line_o(p_line)
   );

   // sum needs 8 bits: lo and hi can both reach 99
   assign g_mid  = 7'((8'(lo_q) + 8'(hi_q)) >> 1);
   assign g_ones = 4'(g_mid % 7'd10);
   assign g_tens = 4'(g_mid / 7'd10);
   assign hcode  = decode_hint(h3_q, h2_q);
   assign p_free = !p_busy || p_ack;

   always_comb begin
      state_d = state_q;
      lo_d    = lo_q;
      hi_d    = hi_q;
      guess_d = guess_q;
      ones_d  = ones_q;
      tens_d  = tens_q;
      rem_o_d = rem_o_q;
      rem_t_d = rem_t_q;
      gcnt_d  = gcnt_q;
      cnt_d   = cnt_q;
      sel_d   = sel_q;
      busy_d  = busy_q;
      won_d   = won_q;
      done_d  = 1'b0;
      p_req   = 1'b0;
      p_tgt   = T_INC;
      unique case (state_q)
         S_IDLE: if (start) begin
            lo_d    = '0;
            hi_d    = 7'(MAX_VALUE);
            gcnt_d  = '0;
            won_d   = 1'b0;
            busy_d  = 1'b1;
            sel_d   = 2'b00;
            p_req   = 1'b1;
            p_tgt   = T_CLR;
            state_d = S_CLEAR;
         end
         S_CLEAR: begin
            ones_d = '0;
            tens_d = '0;
            if (p_ack)
               state_d = S_COMPUTE;
         end
         S_COMPUTE: begin
            guess_d = g_mid;
            rem_o_d = digit_dist(g_ones, ones_q);
            rem_t_d = digit_dist(g_tens, tens_q);
            sel_d   = 2'b01;
            state_d = S_ONES;
         end
         S_ONES: if (p_free) begin
            if (rem_o_q != 0) begin
               p_req   = 1'b1;
               rem_o_d = rem_o_q - 1;
               ones_d  = digit_inc(ones_q);
            end else begin
               sel_d   = 2'b10;
               state_d = S_TENS;
               p_req   = 1'b1;
               if (rem_t_q != 0) begin
                  rem_t_d = rem_t_q - 1;
                  tens_d  = digit_inc(tens_q);
               end else begin
                  p_tgt   = T_SUB;
                  state_d = S_SUBMIT;
               end
            end
         end
         S_TENS: if (p_free) begin
            p_req = 1'b1;
            if (rem_t_q != 0) begin
               rem_t_d = rem_t_q - 1;
               tens_d  = digit_inc(tens_q);
            end else begin
               p_tgt   = T_SUB;
               state_d = S_SUBMIT;
            end
         end
         S_SUBMIT: if (p_ack) begin
            gcnt_d  = gcnt_q + 1;
            cnt_d   = '0;
            state_d = S_SETTLE;
         end
         S_SETTLE: begin
            if (cnt_q == SETTLE_CYCLES - 1) begin
               cnt_d   = '0;
               state_d = S_CLASSIFY;
            end else begin
               cnt_d = cnt_q + 1;
            end
         end
         S_CLASSIFY: begin
            state_d = S_FBWAIT;
            unique case (hcode)
               H_OK: begin
                  won_d   = 1'b1;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  state_d = S_FINISH;
               end
               // guess 0 too high: force lo > hi rather than wrap
               H_HI: if (guess_q == 0) begin
                  lo_d = 7'd1;
                  hi_d = 7'd0;
               end else begin
                  hi_d = guess_q - 7'd1;
               end
               H_LO: lo_d = guess_q + 7'd1;
               default: begin
                  won_d   = 1'b0;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  state_d = S_FINISH;
               end
            endcase
         end
         S_FBWAIT: begin
            if (cnt_q == FB_WAIT - 1) begin
               cnt_d = '0;
               if (gcnt_q == 4'(MAX_GUESSES) || lo_q > hi_q) begin
                  won_d   = 1'b0;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  state_d = S_FINISH;
               end else begin
                  state_d = S_COMPUTE;
               end
            end else begin
               cnt_d = cnt_q + 1;
            end
         end
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge MAX10_CLK1_50 or negedge resetN) begin
      if (!resetN) begin
         state_q <= S_IDLE;
         lo_q    <= '0;
         hi_q    <= 7'(MAX_VALUE);
         guess_q <= '0;
         ones_q  <= '0;
         tens_q  <= '0;
         rem_o_q <= '0;
         rem_t_q <= '0;
         gcnt_q  <= '0;
         cnt_q   <= '0;
         sel_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         won_q   <= 1'b0;
         h3_q    <= HEX_BLANK;
         h2_q    <= HEX_BLANK;
      end else begin
         state_q <= state_d;
         lo_q    <= lo_d;
         hi_q    <= hi_d;
         guess_q <= guess_d;
         ones_q  <= ones_d;
         tens_q  <= tens_d;
         rem_o_q <= rem_o_d;
         rem_t_q <= rem_t_d;
         gcnt_q  <= gcnt_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         won_q   <= won_d;
         h3_q    <= hexIn3;
         h2_q    <= hexIn2;
      end
   end

   assign keyOut     = ~p_line[1:0];
   assign swOut      = {p_line[2], sel_q};
   assign busy       = busy_q;
   assign done       = done_q;
   assign won        = won_q;
   assign guess      = guess_q;
   assign guessCount = gcnt_q;

endmodule

// File: tb/tb_guess_autoplayer.sv
// Autoplayer bench: behavioural game on KEY/SW/HEX plus a
// binary-search model of the expected rounds.
module tb_guess_autoplayer;

   localparam int P    = 4;
   localparam int G    = 4;
   localparam int S    = 16;
   localparam int FB   = 200;
   localparam int MAXG = 7;
   localparam int FEED = 100;

   logic       clk;
   logic       resetN, start;
   logic [7:0] hexIn3, hexIn2;
   logic [1:0] keyOut;
   logic [2:0] swOut;
   logic       busy, done, won;
   logic [6:0] guess;
   logic [3:0] guessCount;

   int n_checks = 0;
   int n_fail   = 0;

   int game_target = 0;
   bit game_err    = 0;
   int g_o, g_t, fb;
   bit gp_k0, gp_k1, gp_sw2;

   int exp_g[16], exp_no[16], exp_nt[16];
   int exp_n;
   bit exp_won;
   int obs_g[16], obs_no[16], obs_nt[16];
   int k, n_on, n_tn, cyc, cyc_sub;
   bit chk_round = 0, fin = 0, done_wait = 0;
   bit c_k0, c_k1;

   guess_autoplayer #(
      .PRESS_CYCLES (P),
      .GAP_CYCLES   (G),
      .SETTLE_CYCLES(S),
      .FB_WAIT      (FB),
      .MAX_GUESSES  (MAXG)
   ) dut (
      .MAX10_CLK1_50(clk),
      .resetN       (resetN),
      .start        (start),
      .hexIn3       (hexIn3),
      .hexIn2       (hexIn2),
      .keyOut       (keyOut),
      .swOut        (swOut),
      .busy         (busy),
      .done         (done),
      .won          (won),
      .guess        (guess),
      .guessCount   (guessCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp_v);
      n_checks++;
      if (act != exp_v) begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
      end
   endtask

   // Expected round from the game rules: binary search over 0..99
   task automatic plan(input int target, input bit err);
      int lo, hi, g, po, pt;
      lo = 0; hi = 99; po = 0; pt = 0;
      exp_n = 0; exp_won = 0;
      while (1) begin
         g = (lo + hi) / 2;
         exp_g[exp_n]  = g;
         exp_no[exp_n] = ((g % 10) - po + 10) % 10;
         exp_nt[exp_n] = ((g / 10) - pt + 10) % 10;
         po = g % 10; pt = g / 10;
         exp_n++;
         if (err) break;
         if (g == target) begin
            exp_won = 1;
            break;
         end
         if (g > target) begin
            if (g == 0) break;
            hi = g - 1;
         end else begin
            lo = g + 1;
         end
         if (exp_n == MAXG || lo > hi) break;
      end
      game_target = target;
      game_err    = err;
      k = 0; n_on = 0; n_tn = 0;
      fin = 0; chk_round = 1;
   endtask

   // Game: digit edit, quick reset, submit and timed hint display
   initial begin
      int v;
      hexIn3 = 8'hFF; hexIn2 = 8'hFF;
      g_o = 0; g_t = 0; fb = 0;
      gp_k0 = 1; gp_k1 = 1; gp_sw2 = 0;
      forever begin
         @(posedge clk);
         #1;
         if (swOut[2] && !gp_sw2) begin
            g_o = 0; g_t = 0;
         end
         if (!keyOut[1] && gp_k1) begin
            if (swOut[1:0] == 2'b01) g_o = (g_o + 1) % 10;
            else if (swOut[1:0] == 2'b10) g_t = (g_t + 1) % 10;
         end
         if (!keyOut[0] && gp_k0) begin
            v = g_t * 10 + g_o;
            if (game_err) begin
               hexIn3 = 8'h86; hexIn2 = 8'hAF;
            end else if (v > game_target) begin
               hexIn3 = 8'h89; hexIn2 = 8'hF9;
            end else if (v < game_target) begin
               hexIn3 = 8'hC7; hexIn2 = 8'hC0;
            end else begin
               hexIn3 = 8'hC0; hexIn2 = 8'h88;
            end
            fb = FEED;
         end else if (fb > 0) begin
            fb--;
            if (fb == 0) begin
               hexIn3 = 8'hFF; hexIn2 = 8'hFF;
            end
         end
         gp_k0 = keyOut[0]; gp_k1 = keyOut[1]; gp_sw2 = swOut[2];
      end
   end

   // Compare process
   initial begin
      int act;
      cyc = 0; cyc_sub = 0; c_k0 = 1; c_k1 = 1;
      forever begin
         @(negedge clk);
         cyc++;
         if (!resetN) begin
            c_k0 = 1; c_k1 = 1; done_wait = 0;
         end else begin
            act = int'(!keyOut[0]) + int'(!keyOut[1]) + int'(swOut[2]);
            chk("one_key_active", int'(act <= 1), 1);
            if (!busy) chk("keys_idle", keyOut, 3);
            if (done_wait) begin
               chk("done_one_cycle", done, 0);
               done_wait = 0;
            end
            if (chk_round) begin
               if (!keyOut[1] && c_k1) begin
                  if (swOut[1:0] == 2'b01) n_on++;
                  else if (swOut[1:0] == 2'b10) n_tn++;
               end
               if (!keyOut[0] && c_k0) begin
                  if (k < exp_n) begin
                     chk("sub_guess", guess, exp_g[k]);
                     chk("sub_entered", g_t * 10 + g_o, exp_g[k]);
                     chk("sub_count", guessCount, k);
                     chk("sub_ones_presses", n_on, exp_no[k]);
                     chk("sub_tens_presses", n_tn, exp_nt[k]);
                     chk("sub_sel_tens", swOut[1:0], 2);
                     obs_g[k] = guess; obs_no[k] = n_on; obs_nt[k] = n_tn;
                  end else begin
                     chk("extra_submit", k, exp_n - 1);
                  end
                  k++;
                  n_on = 0; n_tn = 0;
                  cyc_sub = cyc;
               end
               if (done) begin
                  chk("done_won", won, exp_won);
                  chk("done_count", guessCount, exp_n);
                  chk("done_submits", k, exp_n);
                  chk("done_busy", busy, 0);
                  chk("done_latency", cyc - cyc_sub, P + G + S + 1);
                  fin = 1;
                  done_wait = 1;
               end
            end
            c_k0 = keyOut[0]; c_k1 = keyOut[1];
         end
      end
   end

   task automatic do_start();
      @(negedge clk);
      start = 1;
      @(posedge clk);
      #1;
      chk("first_key_sw2", swOut[2], 1);
      chk("start_busy", busy, 1);
      chk("start_won_clr", won, 0);
      chk("start_cnt", guessCount, 0);
      @(negedge clk);
      start = 0;
   endtask

   task automatic run_round(input int target, input bit err,
                            input bit poke);
      bit hit;
      plan(target, err);
      do_start();
      if (poke) begin
         hit = 0;
         for (int i = 0; i < 2000 && !hit; i++) begin
            @(negedge clk);
            if (guessCount == 1) hit = 1;
         end
         chk("poke_reached", hit, 1);
         start = 1;
         @(negedge clk);
         start = 0;
      end
      for (int i = 0; i < 6000 && !fin; i++)
         @(negedge clk);
      chk("round_finished", fin, 1);
      repeat (3) @(negedge clk);
      chk("won_held", won, exp_won);
      chk("idle_busy", busy, 0);
   endtask

   task automatic cmp_lit(input string nm, input int lit[$]);
      chk({nm, "_len"}, k, lit.size());
      chk({nm, "_model_len"}, exp_n, lit.size());
      foreach (lit[i])
         if (i < 16) chk(nm, obs_g[i], lit[i]);
   endtask

   initial begin
      int l42[$] = '{49, 24, 36, 42};
      int l0[$]  = '{49, 24, 11, 5, 2, 0};
      int l99[$] = '{49, 74, 87, 93, 96, 98, 99};
      bit hit;
      resetN = 0; start = 0;
      repeat (3) @(negedge clk);
      chk("rst_key", keyOut, 3);
      chk("rst_sw", swOut, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_won", won, 0);
      chk("rst_guess", guess, 0);
      chk("rst_count", guessCount, 0);
      resetN = 1;
      repeat (2) @(negedge clk);

      run_round(42, 0, 1);
      cmp_lit("seq42", l42);
      chk("p42_1_ones", obs_no[0], 9);
      chk("p42_1_tens", obs_nt[0], 4);
      chk("p42_2_ones", obs_no[1], 5);
      chk("p42_2_tens", obs_nt[1], 8);
      chk("won42", won, 1);

      run_round(0, 0, 0);
      cmp_lit("seq0", l0);
      chk("won0", won, 1);

      run_round(99, 0, 0);
      cmp_lit("seq99", l99);
      chk("won99", won, 1);
      chk("cnt99", guessCount, 7);

      run_round(42, 1, 0);
      chk("err_submits", k, 1);
      chk("err_won", won, 0);
      chk("err_cnt", guessCount, 1);

      plan(42, 0);
      do_start();
      hit = 0;
      for (int i = 0; i < 3000 && !hit; i++) begin
         @(negedge clk);
         if (busy && guessCount == 1 && swOut[1:0] == 2'b10 && !keyOut[1])
            hit = 1;
      end
      chk("mid_reached", hit, 1);
      resetN = 0;
      chk_round = 0;
      #1;
      chk("mid_key", keyOut, 3);
      chk("mid_sw", swOut, 0);
      chk("mid_busy", busy, 0);
      chk("mid_guess", guess, 0);
      chk("mid_count", guessCount, 0);
      repeat (3) begin
         @(negedge clk);
         chk("mid_no_done", done, 0);
         chk("mid_key_hold", keyOut, 3);
      end
      resetN = 1;
      repeat (2) begin
         @(negedge clk);
         chk("post_rst_no_done", done, 0);
      end

      run_round(42, 0, 0);
      cmp_lit("seq42b", l42);
      chk("won42b", won, 1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
